// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore-style control FSM for a multi-cycle RISC-V datapath with a
//             shared instruction/data memory port and a retired-instr counter.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic        RegWrite,
   output logic        illegal,
   output logic [31:0] instret
);

   localparam logic [3:0] c_FETCH    = 4'd0;
   localparam logic [3:0] c_DECODE   = 4'd1;
   localparam logic [3:0] c_MEMADR   = 4'd2;
   localparam logic [3:0] c_MEMREAD  = 4'd3;
   localparam logic [3:0] c_MEMWB    = 4'd4;
   localparam logic [3:0] c_MEMWRITE = 4'd5;
   localparam logic [3:0] c_EXECUTER = 4'd6;
   localparam logic [3:0] c_EXECUTEI = 4'd7;
   localparam logic [3:0] c_ALUWB    = 4'd8;
   localparam logic [3:0] c_BEQ      = 4'd9;
   localparam logic [3:0] c_JAL      = 4'd10;
   localparam logic [3:0] c_TRAP     = 4'd11;

   localparam logic [6:0] c_OP_LW  = 7'b0000011;
   localparam logic [6:0] c_OP_SW  = 7'b0100011;
   localparam logic [6:0] c_OP_R   = 7'b0110011;
   localparam logic [6:0] c_OP_I   = 7'b0010011;
   localparam logic [6:0] c_OP_BEQ = 7'b1100011;
   localparam logic [6:0] c_OP_JAL = 7'b1101111;

   localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
   localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
   localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

   logic [3:0]  r_state;
   logic [3:0]  w_next_state;
   logic [31:0] r_instret;
   logic [1:0]  w_aluop;
   logic [2:0]  w_alu_funct;
   logic        w_pcwrite;
   logic        w_irwrite;
   logic        w_memwrite;
   logic        w_regwrite;
   logic        w_adrsrc;
   logic [1:0]  w_resultsrc;
   logic [1:0]  w_alusrca;
   logic [1:0]  w_alusrcb;
   logic        w_retire;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_FETCH:    w_next_state = mem_ready ? c_DECODE : c_FETCH;
         c_DECODE: begin
            case (op)
               c_OP_LW,
               c_OP_SW:  w_next_state = c_MEMADR;
               c_OP_R:   w_next_state = c_EXECUTER;
               c_OP_I:   w_next_state = c_EXECUTEI;
               c_OP_BEQ: w_next_state = c_BEQ;
               c_OP_JAL: w_next_state = c_JAL;
               default:  w_next_state = c_TRAP;
            endcase
         end
         c_MEMADR:   w_next_state = (op == c_OP_SW) ? c_MEMWRITE : c_MEMREAD;
         c_MEMREAD:  w_next_state = mem_ready ? c_MEMWB : c_MEMREAD;
         c_MEMWRITE: w_next_state = mem_ready ? c_FETCH : c_MEMWRITE;
         c_EXECUTER,
         c_EXECUTEI,
         c_JAL:      w_next_state = c_ALUWB;
         c_MEMWB,
         c_ALUWB,
         c_BEQ:      w_next_state = c_FETCH;
         c_TRAP:     w_next_state = c_TRAP;
         default:    w_next_state = c_FETCH;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      w_pcwrite   = 1'b0;
      w_irwrite   = 1'b0;
      w_memwrite  = 1'b0;
      w_regwrite  = 1'b0;
      w_adrsrc    = 1'b0;
      w_resultsrc = 2'b00;
      w_alusrca   = 2'b00;
      w_alusrcb   = 2'b00;
      w_aluop     = c_ALUOP_ADD;
      case (r_state)
         c_FETCH: begin
            // PC and IR load only on the cycle the memory delivers the word
            w_irwrite   = mem_ready;
            w_pcwrite   = mem_ready;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
         end
         c_DECODE: begin
            w_alusrca = 2'b01;
            w_alusrcb = 2'b01;
         end
         c_MEMADR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
         end
         c_MEMREAD: begin
            w_adrsrc = 1'b1;
         end
         c_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
         end
         c_MEMWRITE: begin
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         c_EXECUTER: begin
            w_alusrca = 2'b10;
            w_aluop   = c_ALUOP_FUNCT;
         end
         c_EXECUTEI: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
            w_aluop   = c_ALUOP_FUNCT;
         end
         c_ALUWB: begin
            w_regwrite = 1'b1;
         end
         c_BEQ: begin
            // target was computed in DECODE and sits in ALUOut
            w_alusrca = 2'b10;
            w_aluop   = c_ALUOP_SUB;
            w_pcwrite = zero;
         end
         c_JAL: begin
            w_alusrca = 2'b01;
            w_alusrcb = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------- ALU decode
   always_comb begin
      w_alu_funct = 3'b000;
      case (funct3)
         3'b000:  w_alu_funct = (op[5] & funct7b5) ? 3'b001 : 3'b000;
         3'b010:  w_alu_funct = 3'b100;
         3'b110:  w_alu_funct = 3'b011;
         3'b111:  w_alu_funct = 3'b010;
         default: w_alu_funct = 3'b000;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (w_aluop)
         c_ALUOP_SUB:   ALUControl = 3'b001;
         c_ALUOP_FUNCT: ALUControl = w_alu_funct;
         default:       ALUControl = 3'b000;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         c_OP_SW:  ImmSrc = 2'b01;
         c_OP_BEQ: ImmSrc = 2'b10;
         c_OP_JAL: ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

   // ---------------------------------------------------- retire counting
   assign w_retire = (r_state == c_MEMWB) || (r_state == c_ALUWB) ||
                     (r_state == c_BEQ)   || ((r_state == c_MEMWRITE) && mem_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instret <= 32'd0;
      end else if (w_retire) begin
         r_instret <= r_instret + 32'd1;
      end
   end

   // Write enables are gated by reset so an in-flight access dies immediately
   assign PCWrite   = w_pcwrite  & reset;
   assign IRWrite   = w_irwrite  & reset;
   assign MemWrite  = w_memwrite & reset;
   assign RegWrite  = w_regwrite & reset;
   assign AdrSrc    = w_adrsrc;
   assign ResultSrc = w_resultsrc;
   assign ALUSrcA   = w_alusrca;
   assign ALUSrcB   = w_alusrcb;
   assign illegal   = (r_state == c_TRAP);
   assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Self-checking bench: vector table, corner sequences and random
//             instruction streams against a phase-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

   localparam logic [6:0] c_LW  = 7'b0000011;
   localparam logic [6:0] c_SW  = 7'b0100011;
   localparam logic [6:0] c_R   = 7'b0110011;
   localparam logic [6:0] c_I   = 7'b0010011;
   localparam logic [6:0] c_BEQ = 7'b1100011;
   localparam logic [6:0] c_JAL = 7'b1101111;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        zero;
   logic        mem_ready;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]  ALUControl;
   logic [31:0] instret;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .RegWrite(RegWrite), .illegal(illegal),
      .instret(instret)
   );

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       regw;
      logic       ill;
   } exp_t;

   // One phase = one nominal cycle of an instruction; wait phases repeat
   // until mem_ready, gated phases only load PC/IR when mem_ready is high.
   typedef struct {
      exp_t e;
      bit   wait_ready;
      bit   gate_ready;
   } phase_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         cycles;
      logic [2:0] alu3;
      logic [1:0] imm;
      logic       pcw3;
   } vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_instret;
   phase_t      plan[$];
   vec_t        tbl[13];
   exp_t        act;

   assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};

   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, a, e);
      end
   endtask

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      case (o)
         c_SW:    return 2'b01;
         c_BEQ:   return 2'b10;
         c_JAL:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b100;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit legal(input logic [6:0] o);
      return (o == c_LW) || (o == c_SW) || (o == c_R) || (o == c_I) ||
             (o == c_BEQ) || (o == c_JAL);
   endfunction

   function automatic exp_t base(input logic [1:0] im);
      exp_t e;
      e = '0;
      e.imm = im;
      return e;
   endfunction

   task automatic push(input exp_t e, input bit w, input bit g);
      phase_t p;
      p.e = e;
      p.wait_ready = w;
      p.gate_ready = g;
      plan.push_back(p);
   endtask

   task automatic build_plan(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      exp_t       e;
      logic [1:0] im;
      im = imm_of(o);
      plan.delete();
      e = base(im); e.pcw = 1'b1; e.irw = 1'b1; e.res = 2'b10; e.sb = 2'b10;
      push(e, 1'b1, 1'b1);
      e = base(im); e.sa = 2'b01; e.sb = 2'b01;
      push(e, 1'b0, 1'b0);
      if (o == c_LW || o == c_SW) begin
         e = base(im); e.sa = 2'b10; e.sb = 2'b01;
         push(e, 1'b0, 1'b0);
         if (o == c_LW) begin
            e = base(im); e.adr = 1'b1;
            push(e, 1'b1, 1'b0);
            e = base(im); e.res = 2'b01; e.regw = 1'b1;
            push(e, 1'b0, 1'b0);
         end else begin
            e = base(im); e.adr = 1'b1; e.memw = 1'b1;
            push(e, 1'b1, 1'b0);
         end
      end else if (o == c_R || o == c_I) begin
         e = base(im); e.sa = 2'b10; e.sb = (o == c_I) ? 2'b01 : 2'b00;
         e.alu = funct_alu(o, f3, f7);
         push(e, 1'b0, 1'b0);
         e = base(im); e.regw = 1'b1;
         push(e, 1'b0, 1'b0);
      end else if (o == c_BEQ) begin
         e = base(im); e.sa = 2'b10; e.alu = 3'b001; e.pcw = z;
         push(e, 1'b0, 1'b0);
      end else if (o == c_JAL) begin
         e = base(im); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1;
         push(e, 1'b0, 1'b0);
         e = base(im); e.regw = 1'b1;
         push(e, 1'b0, 1'b0);
      end
   endtask

   // Runs one instruction from FETCH; entered and left at posedge+1.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input bit use_mask, input logic [31:0] mask,
                            output int cycles, output logic [2:0] alu3,
                            output logic [1:0] imm3, output logic pcw3);
      int   pi;
      int   stall;
      logic rdy;
      exp_t ex;
      build_plan(o, f3, f7, z);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      pi = 0; stall = 0; cycles = 0; alu3 = '0; imm3 = '0; pcw3 = 1'b0;
      while (pi < plan.size()) begin
         if (use_mask)        rdy = (cycles < 32) ? mask[cycles] : 1'b1;
         else if (stall >= 6) rdy = 1'b1;
         else                 rdy = ($urandom_range(0, 3) != 0);
         mem_ready = rdy;
         @(negedge clk);
         ex = plan[pi].e;
         if (plan[pi].gate_ready) begin
            ex.pcw = ex.pcw & rdy;
            ex.irw = ex.irw & rdy;
         end
         chk("outputs", act, ex);
         chk("instret", instret, exp_instret);
         if (cycles == 2) begin
            alu3 = ALUControl; imm3 = ImmSrc; pcw3 = PCWrite;
         end
         if (!plan[pi].wait_ready || rdy) begin
            pi++;
            stall = 0;
         end else begin
            stall++;
         end
         @(posedge clk); #1;
         cycles++;
         if (pi == plan.size() && legal(o)) exp_instret = exp_instret + 32'd1;
         if (cycles > 200) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: instruction op %b did not finish in 200 cycles", o);
            break;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc;
      logic [2:0] a3;
      logic [1:0] i3;
      logic       p3;
      exp_t       ex;
      logic [6:0] ops[6];

      tbl[0]  = '{c_R,   3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1'b0};
      tbl[1]  = '{c_R,   3'b000, 1'b1, 1'b0, 4, 3'b001, 2'b00, 1'b0};
      tbl[2]  = '{c_R,   3'b010, 1'b0, 1'b0, 4, 3'b100, 2'b00, 1'b0};
      tbl[3]  = '{c_R,   3'b110, 1'b0, 1'b0, 4, 3'b011, 2'b00, 1'b0};
      tbl[4]  = '{c_R,   3'b111, 1'b0, 1'b0, 4, 3'b010, 2'b00, 1'b0};
      tbl[5]  = '{c_R,   3'b100, 1'b1, 1'b0, 4, 3'b000, 2'b00, 1'b0};
      tbl[6]  = '{c_I,   3'b000, 1'b1, 1'b0, 4, 3'b000, 2'b00, 1'b0};
      tbl[7]  = '{c_I,   3'b010, 1'b0, 1'b0, 4, 3'b100, 2'b00, 1'b0};
      tbl[8]  = '{c_LW,  3'b010, 1'b0, 1'b0, 5, 3'b000, 2'b00, 1'b0};
      tbl[9]  = '{c_SW,  3'b010, 1'b0, 1'b0, 4, 3'b000, 2'b01, 1'b0};
      tbl[10] = '{c_BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b001, 2'b10, 1'b1};
      tbl[11] = '{c_BEQ, 3'b000, 1'b0, 1'b0, 3, 3'b001, 2'b10, 1'b0};
      tbl[12] = '{c_JAL, 3'b000, 1'b0, 1'b0, 4, 3'b000, 2'b11, 1'b1};
      ops = '{c_LW, c_SW, c_R, c_I, c_BEQ, c_JAL};

      // reset state: FETCH selects, enables forced low
      reset = 1'b0; mem_ready = 1'b1; op = c_R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
      #1;
      ex = base(imm_of(c_R)); ex.res = 2'b10; ex.sb = 2'b10;
      chk("reset_outputs", act, ex);
      chk("reset_instret", instret, 32'd0);
      exp_instret = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, 1'b1, 32'hFFFF_FFFF, cyc, a3, i3, p3);
         chk("tbl_cycles", cyc, tbl[i].cycles);
         chk("tbl_alu3", a3, tbl[i].alu3);
         chk("tbl_imm", i3, tbl[i].imm);
         chk("tbl_pcw3", p3, tbl[i].pcw3);
      end

      // lw with two not-ready cycles in MEMREAD
      run_instr(c_LW, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFE7, cyc, a3, i3, p3);
      chk("lw_stall_cycles", cyc, 7);
      // fetch stalled twice ahead of a beq
      run_instr(c_BEQ, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, cyc, a3, i3, p3);
      chk("beq_fetch_stall_cycles", cyc, 5);

      for (int i = 0; i < 150; i++) begin
         run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, 32'h0, cyc, a3, i3, p3);
      end

      // reset in the middle of a stalled MEMWRITE
      op = c_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      chk("memwrite_before_reset", MemWrite, 1'b1);
      #2 reset = 1'b0;
      #1 chk("memwrite_cancelled", MemWrite, 1'b0);
      chk("instret_cleared", instret, 32'd0);
      mem_ready = 1'b1;
      #1 chk("enables_in_reset", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
      exp_instret = 32'd0;
      @(posedge clk);
      #2 reset = 1'b1;
      run_instr(c_SW, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0, cyc, a3, i3, p3);
      run_instr(c_R, 3'b111, 1'b0, 1'b0, 1'b0, 32'h0, cyc, a3, i3, p3);

      // unsupported opcode traps and stays trapped
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, cyc, a3, i3, p3);
      for (int i = 0; i < 10; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         zero      = 1'($urandom_range(0, 1));
         @(negedge clk);
         ex = base(2'b00); ex.ill = 1'b1;
         chk("trap_outputs", act, ex);
         chk("trap_instret", instret, exp_instret);
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1 chk("trap_cleared", illegal, 1'b0);
      chk("trap_instret_cleared", instret, 32'd0);
      exp_instret = 32'd0;
      @(posedge clk);
      #2 reset = 1'b1;
      run_instr(c_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, cyc, a3, i3, p3);
      chk("after_trap_jal_cycles", cyc, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit that sequences the RISC-V datapath as a multi-cycle machine, with one shared memory port for instructions and data. It decodes the latched instruction fields and walks a Moore FSM through fetch, decode, execute, memory and writeback. Each cycle it drives every datapath select and write-enable. It also stalls on a memory-ready handshake, traps on unsupported opcodes and counts retired instructions.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  7  opcode from instruction register, bits [6:0]
- funct3  input  3  instruction bits [14:12]
- funct7b5  input  1  instruction bit 30
- zero  input  1  ALU equality flag
- mem_ready  input  1  shared memory completes the current access this cycle
- PCWrite  output  1  PC register load enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register and OldPC load enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RegA
- ALUSrcB  output  2  ALU B select: 00 = RegB, 01 = ImmExt, 10 = constant 4
- ImmSrc  output  2  extend select: I = 00, S = 01, B = 10, J = 11
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- RegWrite  output  1  register file write enable
- illegal  output  1  sticky trap flag
- instret  output  32  retired-instruction counter

## Operation
- States and exits:
  - FETCH → DECODE on mem_ready.
  - DECODE branches by op:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → TRAP
  - MEMADR → MEMREAD for lw, → MEMWRITE for sw.
  - MEMREAD → MEMWB on mem_ready.
  - MEMWRITE → FETCH on mem_ready.
  - EXECUTER, EXECUTEI and JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
  - TRAP is absorbing; only reset leaves it.
- Outputs per state (unlisted enables are 0, unlisted selects are 00):
  - FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUop=add, ResultSrc=10, PCWrite=mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add. Precomputes the branch/jump target.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held for every cycle in the state.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUop=funct.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUop=funct.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - TRAP: illegal=1, all enables 0.
- ALUControl decode:
  - ALUop add → 000.
  - sub → 001.
  - funct decode by funct3:
    - 000 → 001 if op[5] & funct7b5, else 000.
    - 010 → 100.
    - 110 → 011.
    - 111 → 010.
    - other → 000.
- ImmSrc is decoded from op in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else → 00
- instret increments by 1 on the final cycle of each instruction and wraps from 0xFFFFFFFF to 0. The final cycle is:
  - MEMWB or ALUWB
  - BEQ
  - MEMWRITE with mem_ready
- Trapped instructions do not retire.

## Timing
- Reset assertion:
  - Immediately sets state = FETCH, instret = 0, illegal = 0.
  - While reset is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Applies mid-instruction with no partial writeback; an in-flight MEMWRITE is cancelled the same cycle.
- Reset release: the first rising edge with reset high evaluates FETCH normally.
- State register is the only sequential control element. Outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready.
- Latencies with mem_ready constantly 1:
  - beq: 3 cycles
  - R-type, I-type, sw, jal: 4 cycles
  - lw: 5 cycles
- Each cycle mem_ready is 0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable across the stall.
- PCWrite and IRWrite in FETCH assert only in the mem_ready cycle, so the PC advances exactly once per fetch.
- BEQ samples zero in its single cycle. A taken branch loads the target computed in DECODE.

## Test plan
- Reset low mid-MEMWRITE → MemWrite drops the same cycle; after release state = FETCH, instret = 0.
- add (op 0110011, funct3 000, funct7b5 0) with mem_ready = 1 → states FETCH, DECODE, EXECUTER, ALUWB; ALUControl 000 in EXECUTER; RegWrite only in cycle 4; instret 0 → 1.
- sub (funct7b5 1), then lw with mem_ready low for 2 cycles in MEMREAD:
  - sub → ALUControl 001.
  - lw → 7 cycles total; ResultSrc = 01 and RegWrite = 1 in MEMWB.
- beq with zero = 1, then zero = 0:
  - zero = 1 → PCWrite = 1 in BEQ, ImmSrc = 10.
  - zero = 0 → PCWrite = 0.
  - Both → 3-cycle instruction, instret +1.
- jal:
  - ImmSrc = 11.
  - JAL state: ALUSrcA = 01, ALUSrcB = 10, PCWrite = 1.
  - ALUWB: RegWrite = 1.
- op 1111111 → TRAP after DECODE; illegal = 1 sticky; no enables for 10 cycles; instret unchanged until reset.
